ccff_bitstream_loader: RTL and testbench

- Upstream configuration-chain driver for the FPGA fabric's I/O and logic tiles.
- Accepts configuration bytes over a valid/ready stream and serializes them onto the `ccff_head` of a scan chain of CHAIN_LEN flip-flops.
- Produces a clock-enable for an external clock gate on the chain's `prog_clk`, so the chain advances only on real data bits.
- Signals completion once exactly CHAIN_LEN bits have been shifted in.

---
 rtl/ccff_bitstream_loader.sv | 173 +++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Byte-stream to configuration-chain serializer with chain clock-enable and bit counter.
// Optional CCFF_LOADER_READBACK_EN adds a CRC-16-CCITT over the bits returning on ccff_tail.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset_n,
    input  logic                           start,
    input  logic [7:0]                     cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_clk_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
`ifdef CCFF_LOADER_READBACK_EN
    ,
    output logic [15:0]                    readback_crc
`endif
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam logic [CntW-1:0] ChainLen = CntW'(CHAIN_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      sreg_q, sreg_d;
    logic [3:0]      nbits_q, nbits_d;
    logic            head_q, head_d;
    logic            clk_en_q, clk_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [31:0]     remain;

    assign cfg_ready   = (state_q == StFetch);
    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_count   = cnt_q;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        nbits_d  = nbits_q;
        head_d   = head_q;
        clk_en_d = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        remain   = CHAIN_LEN - 32'(cnt_q);
        cnt_inc  = (cnt_q != ChainLen) ? cnt_q + CntW'(1) : cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StFetch: begin
                if (cfg_valid) begin
                    // First bit goes out together with its enable in the first SHIFT cycle.
                    state_d  = StShift;
                    nbits_d  = (remain >= 32'd8) ? 4'd8 : remain[3:0];
                    clk_en_d = 1'b1;
                    if (MSB_FIRST) begin
                        head_d = cfg_data[7];
                        sreg_d = {cfg_data[6:0], 1'b0};
                    end else begin
                        head_d = cfg_data[0];
                        sreg_d = {1'b0, cfg_data[7:1]};
                    end
                end
            end
            StShift: begin
                cnt_d = cnt_inc;
                if (nbits_q == 4'd1) begin
                    if (cnt_inc == ChainLen) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    nbits_d  = nbits_q - 4'd1;
                    clk_en_d = 1'b1;
                    if (MSB_FIRST) begin
                        head_d = sreg_q[7];
                        sreg_d = {sreg_q[6:0], 1'b0};
                    end else begin
                        head_d = sreg_q[0];
                        sreg_d = {1'b0, sreg_q[7:1]};
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
            nbits_q  <= '0;
            head_q   <= 1'b0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            nbits_q  <= nbits_d;
            head_q   <= head_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;

    // The tail bit is valid on exactly the edges where the chain advances.
    always_comb begin
        crc_d  = crc_q;
        crc_fb = crc_q[15] ^ ccff_tail;
        if (start && (state_q == StIdle || state_q == StDone)) begin
            crc_d = 16'hFFFF;
        end else if (clk_en_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign readback_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: unit 0 is CHAIN_LEN=16 MSB-first, unit 1 is CHAIN_LEN=12 LSB-first.
module tb_ccff_bitstream_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       start_s [2];
    logic [7:0] data_s  [2];
    logic       valid_s [2];
    logic       ready_s [2];
    logic       head_s  [2];
    logic       en_s    [2];
    logic       tail_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [4:0] cnt_a;
    logic [3:0] cnt_b;
`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] crc_a, crc_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    bit cap [2][64];
    int en_cnt [2];
    int hold_err [2];
    bit last_head [2];
    bit hold_chk = 1'b0;

    logic [15:0] chain_a = 16'h0000;
    bit          preload = 1'b0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(16), .MSB_FIRST(1'b1)) u_a (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start_s[0]),
        .cfg_data     (data_s[0]),
        .cfg_valid    (valid_s[0]),
        .cfg_ready    (ready_s[0]),
        .ccff_head    (head_s[0]),
        .ccff_clk_en  (en_s[0]),
        .ccff_tail    (tail_s[0]),
        .busy         (busy_s[0]),
        .done         (done_s[0]),
        .bit_count    (cnt_a)
`ifdef CCFF_LOADER_READBACK_EN
        ,
        .readback_crc (crc_a)
`endif
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12), .MSB_FIRST(1'b0)) u_b (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start_s[1]),
        .cfg_data     (data_s[1]),
        .cfg_valid    (valid_s[1]),
        .cfg_ready    (ready_s[1]),
        .ccff_head    (head_s[1]),
        .ccff_clk_en  (en_s[1]),
        .ccff_tail    (tail_s[1]),
        .busy         (busy_s[1]),
        .done         (done_s[1]),
        .bit_count    (cnt_b)
`ifdef CCFF_LOADER_READBACK_EN
        ,
        .readback_crc (crc_b)
`endif
    );

    // Downstream chain of unit 0, shifting MSB-out toward the tail.
    always @(posedge prog_clk) begin
        if (preload) chain_a <= 16'h1234;
        else if (en_s[0]) chain_a <= {chain_a[14:0], head_s[0]};
    end
    assign tail_s[0] = chain_a[15];
    assign tail_s[1] = 1'b0;

    // Capture what the chain takes on each enabled edge; flag head changes while disabled.
    always @(negedge prog_clk) begin
        for (int u = 0; u < 2; u++) begin
            if (en_s[u]) begin
                if (en_cnt[u] < 64) cap[u][en_cnt[u]] = head_s[u];
                en_cnt[u]++;
            end else if (hold_chk && head_s[u] !== last_head[u]) begin
                hold_err[u]++;
            end
            last_head[u] = head_s[u];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_cnt(input int u);
        return (u == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    function automatic int chain_len(input int u);
        return (u == 0) ? 16 : 12;
    endfunction

    // Expected chain bits, first shifted bit at index 0.
    function automatic logic [15:0] model_bits(input int u, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0]  by [2];
        logic [15:0] r;
        int          k;
        r = '0;
        k = 0;
        by[0] = b0;
        by[1] = b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (k < chain_len(u)) begin
                    r[k] = (u == 0) ? by[i][7-j] : by[i][j];
                    k++;
                end
            end
        end
        return r;
    endfunction

    // Cycles from the start edge to done visible: one FETCH per byte plus one per bit.
    function automatic int model_cycles(input int u, input int g0, input int g1);
        int rem, nb, c;
        rem = chain_len(u);
        c = 1 + g0 + g1;
        for (int i = 0; i < 2; i++) begin
            nb = (rem > 8) ? 8 : rem;
            c += 1 + nb;
            rem -= nb;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_ref(input logic [15:0] data);
        logic [15:0] c;
        bit          fb;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic run_load(input int u, input logic [7:0] b0, input logic [7:0] b1,
                            input int g0, input int g1, input bit poke, input logic [15:0] exp);
        logic [7:0]  by [2];
        int          gp [2];
        int          cyc, guard, n;
        logic [15:0] got;
        by[0] = b0; by[1] = b1;
        gp[0] = g0; gp[1] = g1;
        n = chain_len(u);
        en_cnt[u] = 0;
        hold_err[u] = 0;
        start_s[u] = 1'b1;
        step();
        start_s[u] = 1'b0;
        cyc = 1;
        check("start_done_clr", int'(done_s[u]), 0);
        check("start_cnt_clr", get_cnt(u), 0);
        check("start_busy", int'(busy_s[u]), 1);
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            @(negedge prog_clk);
            while (!ready_s[u] && guard < 50) begin
                step();
                cyc++;
                guard++;
                @(negedge prog_clk);
            end
            check("ready_seen", int'(ready_s[u]), 1);
            for (int g = 0; g < gp[i]; g++) begin
                step();
                cyc++;
            end
            if (gp[i] > 0) begin
                @(negedge prog_clk);
                check("ready_held_stall", int'(ready_s[u]), 1);
            end
            data_s[u] = by[i];
            valid_s[u] = 1'b1;
            step();
            cyc++;
            valid_s[u] = 1'b0;
            data_s[u] = 8'($urandom);
            if (poke && i == 0) begin
                start_s[u] = 1'b1;
                step();
                cyc++;
                start_s[u] = 1'b0;
            end
        end
        guard = 0;
        while (!done_s[u] && guard < 100) begin
            step();
            cyc++;
            guard++;
        end
        got = '0;
        for (int i = 0; i < 16; i++) if (i < n) got[i] = cap[u][i];
        check("done", int'(done_s[u]), 1);
        check("busy_done", int'(busy_s[u]), 0);
        check("ready_done", int'(ready_s[u]), 0);
        check("bit_count", get_cnt(u), n);
        check("enable_pulses", en_cnt[u], n);
        check("head_bits", int'(got), int'(exp));
        check("head_hold", hold_err[u], 0);
        check("load_cycles", cyc, model_cycles(u, g0, g1));
    endtask

    typedef struct {
        int          u;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          g0;
        int          g1;
        logic [15:0] seq;  // written in shift order, first bit leftmost of the chain_len bits
    } vec_t;

    vec_t        tab [6];
    logic [15:0] e;
    int          ru, rg0, rg1;
    logic [7:0]  rb0, rb1;

    initial begin
        tab[0] = '{0, 8'hA5, 8'h3C, 0, 0, 16'b1010010100111100};
        tab[1] = '{1, 8'hFF, 8'h0F, 0, 0, 16'b0000111111111111};
        tab[2] = '{0, 8'h00, 8'hFF, 0, 5, 16'b0000000011111111};
        tab[3] = '{1, 8'h81, 8'h35, 5, 0, 16'b0000100000011010};
        tab[4] = '{0, 8'hFF, 8'h00, 0, 5, 16'b1111111100000000};
        tab[5] = '{1, 8'h5A, 8'hF6, 2, 3, 16'b0000010110100110};

        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            data_s[u] = 8'h00;
            valid_s[u] = 1'b0;
            en_cnt[u] = 0;
            hold_err[u] = 0;
        end
        prog_reset_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_ready", int'(ready_s[u]), 0);
            check("rst_head", int'(head_s[u]), 0);
            check("rst_clk_en", int'(en_s[u]), 0);
            check("rst_busy", int'(busy_s[u]), 0);
            check("rst_done", int'(done_s[u]), 0);
            check("rst_cnt", get_cnt(u), 0);
        end
        step();
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        hold_chk = 1'b1;

        // IDLE ignores cfg_valid.
        valid_s[0] = 1'b1;
        data_s[0] = 8'hC3;
        step();
        step();
        valid_s[0] = 1'b0;
        check("idle_ready", int'(ready_s[0]), 0);
        check("idle_clk_en", int'(en_s[0]), 0);
        check("idle_busy", int'(busy_s[0]), 0);

        // Reset in the middle of SHIFT.
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        data_s[0] = 8'hA5;
        valid_s[0] = 1'b1;
        step();
        valid_s[0] = 1'b0;
        step();
        step();
        check("mid_shift_en", int'(en_s[0]), 1);
        hold_chk = 1'b0;
        #2;
        prog_reset_n = 1'b0;
        #1;
        check("mid_rst_head", int'(head_s[0]), 0);
        check("mid_rst_clk_en", int'(en_s[0]), 0);
        check("mid_rst_busy", int'(busy_s[0]), 0);
        check("mid_rst_done", int'(done_s[0]), 0);
        check("mid_rst_cnt", get_cnt(0), 0);
        check("mid_rst_ready", int'(ready_s[0]), 0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        step();
        step();
        check("post_rst_ready", int'(ready_s[0]), 0);
        check("post_rst_busy", int'(busy_s[0]), 0);
        check("post_rst_cnt", get_cnt(0), 0);
        hold_chk = 1'b1;

        for (int t = 0; t < 6; t++) begin
            e = '0;
            for (int i = 0; i < chain_len(tab[t].u); i++) e[i] = tab[t].seq[chain_len(tab[t].u)-1-i];
            run_load(tab[t].u, tab[t].b0, tab[t].b1, tab[t].g0, tab[t].g1, 1'b0, e);
        end

        for (int r = 0; r < 20; r++) begin
            ru = int'($urandom_range(1, 0));
            rb0 = 8'($urandom);
            rb1 = 8'($urandom);
            rg0 = int'($urandom_range(3, 0));
            rg1 = int'($urandom_range(3, 0));
            run_load(ru, rb0, rb1, rg0, rg1, 1'b0, model_bits(ru, rb0, rb1));
        end

        // start pulsed during SHIFT must not disturb the load.
        run_load(0, 8'h96, 8'h0F, 0, 0, 1'b1, model_bits(0, 8'h96, 8'h0F));
        run_load(1, 8'h3B, 8'hE4, 1, 0, 1'b1, model_bits(1, 8'h3B, 8'hE4));

`ifdef CCFF_LOADER_READBACK_EN
        preload = 1'b1;
        step();
        preload = 1'b0;
        run_load(0, 8'hFF, 8'hFF, 0, 0, 1'b0, 16'hFFFF);
        check("readback_crc", int'(crc_a), int'(crc_ref(16'h1234)));
        check("chain_after_load", int'(chain_a), 16'hFFFF);
        step();
        step();
        step();
        check("readback_crc_frozen", int'(crc_a), int'(crc_ref(16'h1234)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
